// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter FIFO.
// The master drives data/valid; the slave returns ready.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO over a valid/ready handshake.
// Frames are sent back to back while the FIFO holds data.
module uart_tx #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   bus,
    output logic       tx,
    output logic       tx_busy
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W        = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               tx_d, busy_d;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr_q, rptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop, empty, ready, bit_end;

    // FIFO status; ready is deliberately combinational so it drops during reset
    assign ready        = (count_q != CNT_W'(FIFO_DEPTH)) & rst;
    assign bus.tx_ready = ready;
    assign push         = bus.tx_valid & ready;
    assign empty        = (count_q == '0);
    assign bit_end      = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign count_d      = count_q + CNT_W'(push) - CNT_W'(pop);

    // FIFO storage needs no reset: only entries below count are ever read
    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= bus.tx_data;
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state   <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx      <= tx_d;
            tx_busy <= busy_d;
            count_q <= count_d;
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:  if (!empty)                          state_d = START;
            START: if (bit_end)                         state_d = DATA;
            DATA:  if (bit_end && idx_q == 3'd7)        state_d = STOP;
            STOP:  if (bit_end)                         state_d = empty ? IDLE : START;
            default:                                    state_d = IDLE;
        endcase
    end

    // Output and datapath logic; tx_d is the line value for the next cycle
    always_comb begin
        tx_d    = tx;
        baud_d  = bit_end ? '0 : baud_q + BAUD_W'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = mem[rptr_q];
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d  = shreg_q[0];
                    idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end && !empty) begin
                    pop     = 1'b1;
                    shreg_d = mem[rptr_q];
                    tx_d    = 1'b0;
                end
            end
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE) || (count_d != '0);
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a shortened bit time (16 clocks per bit).
// Line bits are compared on every clock of each frame against the 8N1 pattern.
module tb_uart_tx;
    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx, tx_busy;
    int   errors = 0;
    int   checks = 0;

    uart_tx_if bus ();

    uart_tx #(.CLK_FREQ(1600), .BAUD(100), .FIFO_DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    // Line bits in send order: start, data LSB first, stop
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    // Compare tx on every cycle of one frame, starting at cycle start_k of that frame
    task automatic check_frame(input logic [7:0] b, input string name, input int start_k,
                               output logic busy_last, output logic ready_last);
        logic [9:0] f;
        int bad;
        int first;
        logic firstv;
        f = frame_of(b);
        bad = 0;
        first = 0;
        firstv = 1'b0;
        busy_last = 1'b0;
        ready_last = 1'b0;
        for (int k = start_k; k < FRAME; k++) begin
            if (tx !== f[k / CPB]) begin
                if (bad == 0) begin first = k; firstv = tx; end
                bad++;
            end
            busy_last = tx_busy;
            ready_last = bus.tx_ready;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_bits: %0d wrong cycles, first at cycle %0d got %b want %b",
                     name, bad, first, firstv, f[first / CPB]);
        end
    endtask

    // Line must stay idle (tx=1, busy=0) for n cycles
    task automatic check_quiet(input string name, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d non-idle cycles, got 0 want idle", name, bad);
        end
    endtask

    task automatic test_reset();
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h77;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.tx_ready); end
        rst = 1'b1;
        bus.tx_valid = 1'b0;
        #1;
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", bus.tx_ready); end
        @(negedge clk);
        check_quiet("reset_nothing_queued", 2 * CPB);
    endtask

    task automatic test_single();
        logic bl, rl;
        @(negedge clk);
        bus.tx_data = 8'hA5;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.tx_valid = 1'b0;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_at_push: got %b want 1", tx); end
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy_at_push: got %b want 1", tx_busy); end
        @(negedge clk);
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL single_latency: got %b want 0", tx); end
        check_frame(8'hA5, "single_a5", 0, bl, rl);
        checks++; if (bl !== 1'b1) begin errors++; $display("FAIL single_busy_last_cycle: got %b want 1", bl); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", tx_busy); end
        check_quiet("single_idle_after", CPB);
    endtask

    task automatic test_back_to_back();
        logic bl, rl;
        @(negedge clk);
        bus.tx_data = 8'hA5;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.tx_data = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        bus.tx_valid = 1'b0;
        check_frame(8'hA5, "b2b_a5", 0, bl, rl);
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL b2b_no_gap: got %b want 0", tx); end
        check_frame(8'h5A, "b2b_5a", 0, bl, rl);
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b want 0", tx_busy); end
    endtask

    task automatic test_full_fifo();
        logic bl, rl;
        @(negedge clk);
        bus.tx_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            bus.tx_data = 8'(i);
            @(posedge clk);
            @(negedge clk);
            if (i == 2) begin
                checks++; if (tx !== 1'b0) begin errors++; $display("FAIL full_first_start: got %b want 0", tx); end
            end
            if (i == 5) begin
                checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b want 0", bus.tx_ready); end
            end
        end
        bus.tx_valid = 1'b0;
        // byte 1 started after push edge 2, so this negedge is cycle 4 of its frame
        check_frame(8'h01, "full_01", 4, bl, rl);
        checks++; if (rl !== 1'b0) begin errors++; $display("FAIL full_ready_before_pop: got %b want 0", rl); end
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b want 1", bus.tx_ready); end
        for (int i = 2; i <= 5; i++) check_frame(8'(i), $sformatf("full_%02x", i), 0, bl, rl);
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL full_busy_end: got %b want 0", tx_busy); end
        check_quiet("full_sixth_dropped", 3 * CPB);
    endtask

    task automatic test_mid_reset();
        logic bl, rl;
        @(negedge clk);
        bus.tx_data = 8'hFF;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.tx_data = 8'h00;
        @(posedge clk);
        @(negedge clk);
        bus.tx_valid = 1'b0;
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midrst_in_bit3: got %b want 1", tx); end
        rst = 1'b0;
        #1;
        checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready_low: got %b want 0", bus.tx_ready); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b want 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", tx_busy); end
        check_quiet("midrst_queue_dropped", 12 * CPB);
        bus.tx_data = 8'h3C;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.tx_valid = 1'b0;
        @(negedge clk);
        check_frame(8'h3C, "midrst_3c", 0, bl, rl);
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_end: got %b want 0", tx_busy); end
    endtask

    initial begin
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full_fifo();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
